// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared encodings for the ID/EX stage register and its load-use hazard check.
package id_ex_pipeline_reg_pkg;

  // ALUOp encodings produced by the main decoder.
  localparam logic [1:0] ALUOP_LWSW    = 2'b00;
  localparam logic [1:0] ALUOP_BEQ     = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
  localparam logic [1:0] ALUOP_UNKNOWN = 2'b11;

  // A bubble carries the harmless add-style ALUOp.
  localparam logic [1:0] ALUOP_BUBBLE  = ALUOP_LWSW;

  // Register $0 is hard-wired to zero and can never be a hazard source.
  localparam int unsigned REG_ZERO = 0;

  // Decoded control bundle carried from ID into EX.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  // Control word of a bubble: nothing writes, nothing touches memory.
  localparam ctrl_t CTRL_BUBBLE = '{
    reg_dst:    1'b0,
    alu_src:    1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    reg_write:  1'b0,
    alu_op:     ALUOP_BUBBLE
  };

endpackage

// File: rtl/ID_Hazard_Detection.sv
// Load-use hazard detector: requests a one-cycle stall when the load now in
// EX writes a register that the instruction in ID is about to read.
module ID_Hazard_Detection
  import id_ex_pipeline_reg_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      MemRead_EX,
  input  logic                      Valid_EX,
  input  logic [REG_ADDR_WIDTH-1:0] Rt_EX,
  input  logic [REG_ADDR_WIDTH-1:0] Rs_ID,
  input  logic [REG_ADDR_WIDTH-1:0] Rt_ID,
  input  logic                      Hold,
  input  logic                      Flush,
  output logic                      Stall_ID
);

  logic load_in_ex;
  logic rt_not_zero;
  logic operand_match;

  // Compare the EX load destination against both ID source specifiers; a
  // freeze or a flush already decides what EX captures, so the stall is masked.
  always_comb begin
    load_in_ex    = MemRead_EX && Valid_EX;
    rt_not_zero   = (Rt_EX != REG_ADDR_WIDTH'(REG_ZERO));
    operand_match = (Rt_EX == Rs_ID) || (Rt_EX == Rt_ID);
    Stall_ID      = load_in_ex && rt_not_zero && operand_match && !Hold && !Flush;
  end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with freeze, flush-to-bubble and load-use stall.
// Edge priority: Reset > Hold > Flush > Stall_ID > normal load.
module id_ex_pipeline_reg
  import id_ex_pipeline_reg_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Hold,
  input  logic                      Flush,
  input  logic [DATA_WIDTH-1:0]     PC_Plus_4_ID,
  input  logic [DATA_WIDTH-1:0]     Read_Data_1_ID,
  input  logic [DATA_WIDTH-1:0]     Read_Data_2_ID,
  input  logic [DATA_WIDTH-1:0]     Sign_Extend_Instruction_ID,
  input  logic [REG_ADDR_WIDTH-1:0] Rs_ID,
  input  logic [REG_ADDR_WIDTH-1:0] Rt_ID,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_ID,
  input  logic                      RegDst_ID,
  input  logic                      ALUSrc_ID,
  input  logic                      MemRead_ID,
  input  logic                      MemWrite_ID,
  input  logic                      MemtoReg_ID,
  input  logic                      RegWrite_ID,
  input  logic [1:0]                ALUOp_ID,
  output logic [DATA_WIDTH-1:0]     PC_Plus_4_EX,
  output logic [DATA_WIDTH-1:0]     Read_Data_1_EX,
  output logic [DATA_WIDTH-1:0]     Read_Data_2_EX,
  output logic [DATA_WIDTH-1:0]     Sign_Extend_Instruction_EX,
  output logic [REG_ADDR_WIDTH-1:0] Rs_EX,
  output logic [REG_ADDR_WIDTH-1:0] Rt_EX,
  output logic [REG_ADDR_WIDTH-1:0] Rd_EX,
  output logic                      RegDst_EX,
  output logic                      ALUSrc_EX,
  output logic                      MemRead_EX,
  output logic                      MemWrite_EX,
  output logic                      MemtoReg_EX,
  output logic                      RegWrite_EX,
  output logic [1:0]                ALUOp_EX,
  output logic                      Valid_EX,
  output logic                      Stall_ID
);

  // Stage state and its next-state values.
  logic [DATA_WIDTH-1:0]     pc_plus_4_q, pc_plus_4_d;
  logic [DATA_WIDTH-1:0]     read_data_1_q, read_data_1_d;
  logic [DATA_WIDTH-1:0]     read_data_2_q, read_data_2_d;
  logic [DATA_WIDTH-1:0]     sign_ext_q, sign_ext_d;
  logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d;
  logic [REG_ADDR_WIDTH-1:0] rt_q, rt_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  ctrl_t                     ctrl_q, ctrl_d;
  logic                      valid_q, valid_d;

  ctrl_t ctrl_id;
  logic  stall;

  assign ctrl_id = '{
    reg_dst:    RegDst_ID,
    alu_src:    ALUSrc_ID,
    mem_read:   MemRead_ID,
    mem_write:  MemWrite_ID,
    mem_to_reg: MemtoReg_ID,
    reg_write:  RegWrite_ID,
    alu_op:     ALUOp_ID
  };

  ID_Hazard_Detection #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_hazard (
    .MemRead_EX(ctrl_q.mem_read),
    .Valid_EX  (valid_q),
    .Rt_EX     (rt_q),
    .Rs_ID     (Rs_ID),
    .Rt_ID     (Rt_ID),
    .Hold      (Hold),
    .Flush     (Flush),
    .Stall_ID  (stall)
  );

  // Choose what EX captures next: keep it (Hold), a bubble (Flush or stall),
  // or the instruction currently in ID.
  always_comb begin
    pc_plus_4_d   = pc_plus_4_q;
    read_data_1_d = read_data_1_q;
    read_data_2_d = read_data_2_q;
    sign_ext_d    = sign_ext_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    rd_d          = rd_q;
    ctrl_d        = ctrl_q;
    valid_d       = valid_q;
    if (Hold) begin
      // freeze: defaults already retain every field
    end else if (Flush || stall) begin
      pc_plus_4_d   = '0;
      read_data_1_d = '0;
      read_data_2_d = '0;
      sign_ext_d    = '0;
      rs_d          = '0;
      rt_d          = '0;
      rd_d          = '0;
      ctrl_d        = CTRL_BUBBLE;
      valid_d       = 1'b0;
    end else begin
      pc_plus_4_d   = PC_Plus_4_ID;
      read_data_1_d = Read_Data_1_ID;
      read_data_2_d = Read_Data_2_ID;
      sign_ext_d    = Sign_Extend_Instruction_ID;
      rs_d          = Rs_ID;
      rt_d          = Rt_ID;
      rd_d          = Rd_ID;
      ctrl_d        = ctrl_id;
      valid_d       = 1'b1;
    end
  end

  // Stage register: reset loads a bubble and overrides every other request.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_plus_4_q   <= '0;
      read_data_1_q <= '0;
      read_data_2_q <= '0;
      sign_ext_q    <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      ctrl_q        <= CTRL_BUBBLE;
      valid_q       <= 1'b0;
    end else begin
      pc_plus_4_q   <= pc_plus_4_d;
      read_data_1_q <= read_data_1_d;
      read_data_2_q <= read_data_2_d;
      sign_ext_q    <= sign_ext_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      rd_q          <= rd_d;
      ctrl_q        <= ctrl_d;
      valid_q       <= valid_d;
    end
  end

  assign PC_Plus_4_EX               = pc_plus_4_q;
  assign Read_Data_1_EX             = read_data_1_q;
  assign Read_Data_2_EX             = read_data_2_q;
  assign Sign_Extend_Instruction_EX = sign_ext_q;
  assign Rs_EX                      = rs_q;
  assign Rt_EX                      = rt_q;
  assign Rd_EX                      = rd_q;
  assign RegDst_EX                  = ctrl_q.reg_dst;
  assign ALUSrc_EX                  = ctrl_q.alu_src;
  assign MemRead_EX                 = ctrl_q.mem_read;
  assign MemWrite_EX                = ctrl_q.mem_write;
  assign MemtoReg_EX                = ctrl_q.mem_to_reg;
  assign RegWrite_EX                = ctrl_q.reg_write;
  assign ALUOp_EX                   = ctrl_q.alu_op;
  assign Valid_EX                   = valid_q;
  assign Stall_ID                   = stall;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Bench for the ID/EX stage register: directed scenarios plus a random
// back-to-back run, each checking EX contents against a queue of expectations.
module tb_id_ex_pipeline_reg;
  import id_ex_pipeline_reg_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int EW = 4*DW + 3*AW + 9;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset, Hold, Flush;
  logic [DW-1:0] PC_Plus_4_ID, Read_Data_1_ID, Read_Data_2_ID, Sign_Extend_Instruction_ID;
  logic [AW-1:0] Rs_ID, Rt_ID, Rd_ID;
  logic RegDst_ID, ALUSrc_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, RegWrite_ID;
  logic [1:0] ALUOp_ID;
  logic [DW-1:0] PC_Plus_4_EX, Read_Data_1_EX, Read_Data_2_EX, Sign_Extend_Instruction_EX;
  logic [AW-1:0] Rs_EX, Rt_EX, Rd_EX;
  logic RegDst_EX, ALUSrc_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, RegWrite_EX;
  logic [1:0] ALUOp_EX;
  logic Valid_EX, Stall_ID;

  id_ex_pipeline_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Hold(Hold), .Flush(Flush),
    .PC_Plus_4_ID(PC_Plus_4_ID), .Read_Data_1_ID(Read_Data_1_ID),
    .Read_Data_2_ID(Read_Data_2_ID), .Sign_Extend_Instruction_ID(Sign_Extend_Instruction_ID),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID),
    .RegDst_ID(RegDst_ID), .ALUSrc_ID(ALUSrc_ID), .MemRead_ID(MemRead_ID),
    .MemWrite_ID(MemWrite_ID), .MemtoReg_ID(MemtoReg_ID), .RegWrite_ID(RegWrite_ID),
    .ALUOp_ID(ALUOp_ID),
    .PC_Plus_4_EX(PC_Plus_4_EX), .Read_Data_1_EX(Read_Data_1_EX),
    .Read_Data_2_EX(Read_Data_2_EX), .Sign_Extend_Instruction_EX(Sign_Extend_Instruction_EX),
    .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX),
    .RegDst_EX(RegDst_EX), .ALUSrc_EX(ALUSrc_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .MemtoReg_EX(MemtoReg_EX), .RegWrite_EX(RegWrite_EX),
    .ALUOp_EX(ALUOp_EX), .Valid_EX(Valid_EX), .Stall_ID(Stall_ID)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v;

  // EX entry layout, LSB first: valid, aluop[2:1], regwrite, memtoreg,
  // memwrite, memread[6], alusrc, regdst, rd[13:9], rt[18:14], rs[23:19], data.
  function automatic logic [EW-1:0] ex_pack();
    return {PC_Plus_4_EX, Read_Data_1_EX, Read_Data_2_EX, Sign_Extend_Instruction_EX,
            Rs_EX, Rt_EX, Rd_EX, RegDst_EX, ALUSrc_EX, MemRead_EX, MemWrite_EX,
            MemtoReg_EX, RegWrite_EX, ALUOp_EX, Valid_EX};
  endfunction

  // What a normal load of the currently driven ID inputs must produce.
  function automatic logic [EW-1:0] id_pack();
    return {PC_Plus_4_ID, Read_Data_1_ID, Read_Data_2_ID, Sign_Extend_Instruction_ID,
            Rs_ID, Rt_ID, Rd_ID, RegDst_ID, ALUSrc_ID, MemRead_ID, MemWrite_ID,
            MemtoReg_ID, RegWrite_ID, ALUOp_ID, 1'b1};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                           input logic [AW-1:0] rd, input ctrl_t c,
                           input logic [DW-1:0] imm);
    PC_Plus_4_ID               = $urandom;
    Read_Data_1_ID             = $urandom;
    Read_Data_2_ID             = $urandom;
    Sign_Extend_Instruction_ID = imm;
    Rs_ID = rs; Rt_ID = rt; Rd_ID = rd;
    RegDst_ID   = c.reg_dst;   ALUSrc_ID   = c.alu_src;
    MemRead_ID  = c.mem_read;  MemWrite_ID = c.mem_write;
    MemtoReg_ID = c.mem_to_reg; RegWrite_ID = c.reg_write;
    ALUOp_ID    = c.alu_op;
    #1;
  endtask

  task automatic rand_id(input int reg_max);
    ctrl_t c;
    c = ctrl_t'($urandom_range(0, 255));
    set_instr(AW'($urandom_range(0, reg_max)), AW'($urandom_range(0, reg_max)),
              AW'($urandom_range(0, 31)), c, $urandom);
  endtask

  localparam ctrl_t C_ADD = '{reg_dst:1'b1, alu_src:1'b0, mem_read:1'b0, mem_write:1'b0,
                              mem_to_reg:1'b0, reg_write:1'b1, alu_op:ALUOP_RTYPE};
  localparam ctrl_t C_LW  = '{reg_dst:1'b0, alu_src:1'b1, mem_read:1'b1, mem_write:1'b0,
                              mem_to_reg:1'b1, reg_write:1'b1, alu_op:ALUOP_LWSW};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rand_id(31);
    Reset = 1'b1; Hold = 1'b1; Flush = 1'b1;
    exp_q.push_back('0);
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (ex_pack() !== exp_v) begin
      errors++; $display("FAIL reset_entry: got %h expected %h", ex_pack(), exp_v);
    end
    checks++;
    if (ALUOp_EX !== ALUOP_BUBBLE || Valid_EX !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: aluop=%b valid=%b expected 00/0", ALUOp_EX, Valid_EX);
    end
    checks++;
    if (Stall_ID !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", Stall_ID);
    end
    Reset = 1'b0; Hold = 1'b0; Flush = 1'b0;
  endtask

  task automatic test_add();
    set_instr(5'd1, 5'd2, 5'd3, C_ADD, 32'h0000_1820);
    checks++;
    if (Stall_ID !== 1'b0) begin
      errors++; $display("FAIL add_stall: got %b expected 0", Stall_ID);
    end
    exp_q.push_back(id_pack());
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (ex_pack() !== exp_v) begin
      errors++; $display("FAIL add_load: got %h expected %h", ex_pack(), exp_v);
    end
    checks++;
    if (Valid_EX !== 1'b1) begin
      errors++; $display("FAIL add_valid: got %b expected 1", Valid_EX);
    end
  endtask

  task automatic test_load_use();
    logic [EW-1:0] add_v;
    int stall_cycles;
    stall_cycles = 0;
    set_instr(5'd1, 5'd5, 5'd0, C_LW, 32'd4);
    exp_q.push_back(id_pack());
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (ex_pack() !== exp_v) begin
      errors++; $display("FAIL lu_load: got %h expected %h", ex_pack(), exp_v);
    end
    // dependent add $6,$5,$2 held in ID while stalled
    set_instr(5'd5, 5'd2, 5'd6, C_ADD, 32'h0000_3020);
    add_v = id_pack();
    for (int i = 0; i < 4 && exp_q.size() == 0; i++) begin
      if (Stall_ID === 1'b1) begin
        stall_cycles++;
        exp_q.push_back('0);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (ex_pack() !== exp_v) begin
          errors++; $display("FAIL lu_bubble: got %h expected %h", ex_pack(), exp_v);
        end
      end else begin
        exp_q.push_back(add_v);
      end
    end
    checks++;
    if (stall_cycles != 1) begin
      errors++; $display("FAIL lu_stall_count: got %0d expected 1", stall_cycles);
    end
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (ex_pack() !== exp_v) begin
      errors++; $display("FAIL lu_dependent: got %h expected %h", ex_pack(), exp_v);
    end
  endtask

  task automatic test_zero_reg();
    set_instr(5'd1, 5'd0, 5'd0, C_LW, 32'd0);
    exp_q.push_back(id_pack());
    step();
    exp_v = exp_q.pop_front();
    set_instr(5'd0, 5'd2, 5'd6, C_ADD, 32'h0000_3020);
    checks++;
    if (Stall_ID !== 1'b0) begin
      errors++; $display("FAIL zero_reg_stall: got %b expected 0", Stall_ID);
    end
    exp_q.push_back(id_pack());
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (ex_pack() !== exp_v) begin
      errors++; $display("FAIL zero_reg_load: got %h expected %h", ex_pack(), exp_v);
    end
  endtask

  task automatic test_flush();
    set_instr(5'd1, 5'd5, 5'd0, C_LW, 32'd4);
    exp_q.push_back(id_pack());
    step();
    exp_v = exp_q.pop_front();
    set_instr(5'd5, 5'd2, 5'd6, C_ADD, 32'h0000_3020);
    Flush = 1'b1;
    #1;
    checks++;
    if (Stall_ID !== 1'b0) begin
      errors++; $display("FAIL flush_stall: got %b expected 0", Stall_ID);
    end
    exp_q.push_back('0);
    step();
    Flush = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (ex_pack() !== exp_v || Valid_EX !== 1'b0) begin
      errors++; $display("FAIL flush_bubble: got %h expected %h", ex_pack(), exp_v);
    end
  endtask

  task automatic test_hold();
    logic [EW-1:0] held_v;
    set_instr(5'd1, 5'd2, 5'd3, C_ADD, 32'h0000_1820);
    held_v = id_pack();
    exp_q.push_back(held_v);
    step();
    exp_v = exp_q.pop_front();
    Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id(31);
      exp_q.push_back(held_v);
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if (ex_pack() !== exp_v) begin
        errors++; $display("FAIL hold_keep%0d: got %h expected %h", i, ex_pack(), exp_v);
      end
    end
    Hold = 1'b0;
    set_instr(5'd7, 5'd8, 5'd9, C_ADD, $urandom);
    exp_q.push_back(id_pack());
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (ex_pack() !== exp_v) begin
      errors++; $display("FAIL hold_release: got %h expected %h", ex_pack(), exp_v);
    end
  endtask

  task automatic test_reset_mid_stall();
    set_instr(5'd1, 5'd5, 5'd0, C_LW, 32'd4);
    step();
    set_instr(5'd2, 5'd5, 5'd6, C_ADD, 32'h0);
    checks++;
    if (Stall_ID !== 1'b1) begin
      errors++; $display("FAIL rst_stall_pre: got %b expected 1", Stall_ID);
    end
    Reset = 1'b1;
    exp_q.push_back('0);
    step();
    Reset = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (ex_pack() !== exp_v || Stall_ID !== 1'b0) begin
      errors++; $display("FAIL rst_stall_post: got %h stall=%b expected %h stall=0",
                         ex_pack(), Stall_ID, exp_v);
    end
  endtask

  // Random traffic with small register numbers so hazards are frequent.
  task automatic test_back_to_back();
    logic [EW-1:0] m_ex, nxt;
    logic exp_stall;
    Reset = 1'b1; rand_id(31);
    step();
    Reset = 1'b0;
    m_ex = '0;
    for (int n = 0; n < 300; n++) begin
      rand_id(3);
      Hold  = ($urandom_range(0, 7) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      Reset = ($urandom_range(0, 31) == 0);
      #1;
      exp_stall = !Hold && !Flush && m_ex[0] && m_ex[6] && (m_ex[18:14] != 5'd0) &&
                  (m_ex[18:14] == Rs_ID || m_ex[18:14] == Rt_ID);
      checks++;
      if (Stall_ID !== exp_stall) begin
        errors++; $display("FAIL rnd_stall[%0d]: got %b expected %b", n, Stall_ID, exp_stall);
      end
      if (Reset)                  nxt = '0;
      else if (Hold)              nxt = m_ex;
      else if (Flush || exp_stall) nxt = '0;
      else                        nxt = id_pack();
      exp_q.push_back(nxt);
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if (ex_pack() !== exp_v) begin
        errors++; $display("FAIL rnd_entry[%0d]: got %h expected %h", n, ex_pack(), exp_v);
      end
      m_ex = exp_v;
    end
    Hold = 1'b0; Flush = 1'b0; Reset = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    Reset = 1'b1; Hold = 1'b0; Flush = 1'b0;
    test_reset();
    test_add();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_hold();
    test_reset_mid_stall();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
ID_EX_PIPELINE_REG -- requirements
Module: ID_EX_Pipeline_Reg

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of register-file operands, sign-extended immediate and PC+4.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, width of register specifiers.
REQ-003 Clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Hold  in  1  downstream freeze: stage register retains its contents.
REQ-006 Flush  in  1  branch taken: next captured EX entry is a bubble.
REQ-007 PC_Plus_4_ID, Read_Data_1_ID, Read_Data_2_ID, Sign_Extend_Instruction_ID  in  DATA_WIDTH each  ID-stage datapath values.
REQ-008 Rs_ID, Rt_ID, Rd_ID  in  REG_ADDR_WIDTH each  ID-stage register specifiers.
REQ-009 RegDst_ID, ALUSrc_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, RegWrite_ID  in  1 each; ALUOp_ID  in  2  decoded ID controls.
REQ-010 Matching *_EX outputs, same widths: registered copies of every REQ-007..REQ-009 input.
REQ-011 Valid_EX  out  1  EX entry holds a real instruction, not a bubble.
REQ-012 Stall_ID  out  1  load-use hazard: IF/ID register and PC must not advance this cycle.

Function
REQ-013 Stall_ID SHALL be combinational: 1 when MemRead_EX=1, Valid_EX=1, Rt_EX!=0, and (Rt_EX==Rs_ID or Rt_EX==Rt_ID); else 0.
REQ-014 Stall_ID SHALL be forced to 0 while Hold=1 or Flush=1.
REQ-015 Per-edge update priority SHALL be: Reset > Hold > Flush > Stall_ID > normal load.
REQ-016 Hold=1: every *_EX output and Valid_EX SHALL keep its value.
REQ-017 Flush=1 or Stall_ID=1, Hold=0: stage SHALL load a bubble.
REQ-018 Bubble: RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, RegDst_EX, ALUSrc_EX, Valid_EX = 0; ALUOp_EX = 2'b00; all data/specifier outputs = 0.
REQ-019 Normal load: every *_EX output SHALL equal its *_ID input one cycle later; Valid_EX=1.
REQ-020 Latency ID->EX SHALL be exactly 1 cycle; a stall SHALL insert exactly one bubble per stalled cycle.
REQ-021 Load followed by dependent instruction SHALL produce exactly one stall cycle, after which the dependent instruction is loaded normally.
REQ-022 Flush and load-use coincident: flush wins; one bubble; Stall_ID=0.
REQ-023 A bubble in EX (Valid_EX=0) SHALL never raise Stall_ID.
REQ-024 No output SHALL be X after the first reset edge, regardless of *_ID inputs.

Reset
REQ-025 Reset=1 at a rising edge SHALL load the bubble of REQ-018, overriding Hold and Flush.
REQ-026 Reset asserted mid-stall SHALL drop Stall_ID to 0 on the following cycle (EX no longer a load).
REQ-027 Initial-block initialisation SHALL NOT be relied on; Reset is the only defined start state.

Structure
REQ-028 Shared package SHALL hold ALUOp encodings (LWSW 2'b00, BEQ 2'b01, RTYPE 2'b10, UNKNOWN 2'b11), bubble ALUOp constant and REG_ZERO.
REQ-029 Hazard comparison SHALL live in one combinational sub-module ID_Hazard_Detection (inputs MemRead_EX, Valid_EX, Rt_EX, Rs_ID, Rt_ID, Hold, Flush; output Stall_ID).
REQ-030 The stage register SHALL be a single clocked process in the top module.

Verification
REQ-031 Reset=1 one edge with random *_ID -> all *_EX 0, ALUOp_EX=00, Valid_EX=0, Stall_ID=0.
REQ-032 add $3,$1,$2 (Rs=1,Rt=2,Rd=3, RegWrite=1, ALUOp=10, funct 0x20) -> next cycle identical *_EX values, Valid_EX=1.
REQ-033 lw $5,4($1) then add $6,$5,$2 -> Stall_ID=1 one cycle, bubble in EX, add reaches EX cycle after; total 1 stall.
REQ-034 lw $0,0($1) then add $6,$0,$2 -> Stall_ID stays 0.
REQ-035 lw $5 in EX, dependent in ID, Flush=1 same cycle -> Stall_ID=0, bubble loaded, Valid_EX=0.
REQ-036 Valid add in EX, Hold=1 three cycles with changing *_ID -> *_EX unchanged; Hold=0 -> current *_ID loaded next edge.
